// File: rtl/stopwatch_control.sv
// ============================================================================
// stopwatch_control : button edge detect, run/lap/stop FSM and BCD mm:ss.cc
// time base feeding the 6-digit display word.  Rev 1.0
// ============================================================================
`default_nettype none

module stopwatch_control #(
   parameter int TICK_DIV = 500000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        btn_start_stop,
   input  logic        btn_lap,
   input  logic        btn_clear,
   output logic [23:0] disp_bcd,
   output logic        running,
   output logic        lap_active,
   output logic        overflow
);

   localparam int            PW        = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_LAP  = 2'd2;
   localparam logic [1:0] S_STOP = 2'd3;

   // bit 0 start/stop, bit 1 lap, bit 2 clear
   logic [2:0]    btn_q1_q, btn_q2_q;
   logic [1:0]    state_q, state_d;
   logic [PW-1:0] presc_q, presc_d;
   logic [23:0]   time_q, time_d;
   logic [23:0]   lap_q, lap_d;
   logic [23:0]   disp_q, disp_d;
   logic          ovf_q, ovf_d;

   logic [2:0]    w_edge;
   logic          w_ss, w_lap, w_clr;
   logic          w_counting, w_tick, w_wrap;
   logic [23:0]   w_time_inc;
   logic [3:0]    w_lim;

   assign w_edge = btn_q1_q & ~btn_q2_q;
   assign w_ss   = w_edge[0];
   assign w_clr  = w_edge[2] & ~w_ss;
   assign w_lap  = w_edge[1] & ~w_ss & ~w_edge[2];

   assign w_counting = (state_q == S_RUN) || (state_q == S_LAP);
   assign w_tick     = w_counting && (presc_q == TICK_LAST);

   // Ripple BCD increment; digits 3 (sec tens) and 5 (min tens) roll at 5.
   always_comb begin
      w_time_inc = time_q;
      w_wrap     = 1'b1;
      w_lim      = 4'd9;
      for (int i = 0; i < 6; i++) begin
         w_lim = ((i == 3) || (i == 5)) ? 4'd5 : 4'd9;
         if (w_wrap) begin
            if (time_q[i*4 +: 4] == w_lim) begin
               w_time_inc[i*4 +: 4] = 4'd0;
            end else begin
               w_time_inc[i*4 +: 4] = time_q[i*4 +: 4] + 4'd1;
               w_wrap               = 1'b0;
            end
         end
      end
   end

   always_comb begin
      state_d = state_q;
      lap_d   = lap_q;
      case (state_q)
         S_IDLE: if (w_ss) state_d = S_RUN;
         S_RUN: begin
            if (w_ss) begin
               state_d = S_STOP;
            end else if (w_lap) begin
               state_d = S_LAP;
               lap_d   = time_q;
            end
         end
         S_LAP: begin
            if (w_ss)       state_d = S_STOP;
            else if (w_lap) state_d = S_RUN;
         end
         S_STOP: begin
            if (w_ss)       state_d = S_RUN;
            else if (w_clr) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      presc_d = presc_q;
      if (w_counting) presc_d = w_tick ? '0 : presc_q + 1'b1;
      time_d = w_tick ? w_time_inc : time_q;
      ovf_d  = ovf_q | (w_tick & w_wrap);

      if (state_d == S_IDLE) begin
         presc_d = '0;
         time_d  = '0;
         lap_d   = '0;
         ovf_d   = 1'b0;
      end

      disp_d = (state_d == S_LAP) ? lap_d : time_d;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         // Load the live level so a button held through reset gives no edge.
         btn_q1_q <= {btn_clear, btn_lap, btn_start_stop};
         btn_q2_q <= {btn_clear, btn_lap, btn_start_stop};
         state_q  <= S_IDLE;
         presc_q  <= '0;
         time_q   <= '0;
         lap_q    <= '0;
         disp_q   <= '0;
         ovf_q    <= 1'b0;
      end else begin
         btn_q1_q <= {btn_clear, btn_lap, btn_start_stop};
         btn_q2_q <= btn_q1_q;
         state_q  <= state_d;
         presc_q  <= presc_d;
         time_q   <= time_d;
         lap_q    <= lap_d;
         disp_q   <= disp_d;
         ovf_q    <= ovf_d;
      end
   end

   assign disp_bcd   = disp_q;
   assign running    = w_counting;
   assign lap_active = (state_q == S_LAP);
   assign overflow   = ovf_q;

endmodule

`default_nettype wire
